bist_fail_logger: RTL and testbench

Downstream consumer of the bit-line BIST engine. It samples the engine's per-cycle `fail`/`fail_addr`/`data_out` stream during a test run and builds a deduplicated log of failing addresses. It also keeps a saturating total-fail count, judges repairability against a spare-row budget, and drains the log after the run over a valid/ready readout port. It sits between the BIST engine and the repair/ATE interface; it never drives the SRAM.

---
 rtl/bist_fail_logger_if.sv | 25 ++
 rtl/bist_fail_logger.sv | 192 +++++++++++++++++++
 tb/tb_bist_fail_logger.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bist_fail_logger_if.sv
// Readout port of the BIST fail logger: one logged {address, first failing word}
// per valid/ready transfer, drained after the test run.
interface bist_fail_logger_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int WORD_WIDTH = 4
);
    logic                  rd_valid;
    logic                  rd_ready;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [WORD_WIDTH-1:0] rd_data;

    modport master (
        output rd_valid,
        output rd_addr,
        output rd_data,
        input  rd_ready
    );

    modport slave (
        input  rd_valid,
        input  rd_addr,
        input  rd_data,
        output rd_ready
    );
endinterface

// File: rtl/bist_fail_logger.sv
// BIST fail logger: watches the BIST fail stream during a run, keeps a
// deduplicated log of failing addresses with the first failing word for each,
// counts all fail cycles (saturating), judges repairability against the spare
// row budget and drains the log over a valid/ready port once the run ends.
//
// state   | meaning
// --------+----------------------------------------------------------------
// S_IDLE  | no run; every output held at zero
// S_LOG   | run in progress; fail sampled every cycle incl. first low cycle
// S_DRAIN | run over, log non-empty; entries presented in index order
// S_DONE  | run over and drained; run_done/pass/repairable valid, log kept
//
// Assumes DEPTH >= 2.
module bist_fail_logger #(
    parameter int ADDR_WIDTH = 8,
    parameter int WORD_WIDTH = 4,
    parameter int DEPTH      = 8,
    parameter int SPARE_ROWS = 2,
    parameter int CNT_WIDTH  = 10
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         test_active,
    input  logic                         fail,
    input  logic [ADDR_WIDTH-1:0]        fail_addr,
    input  logic [WORD_WIDTH-1:0]        fail_data,
    input  logic                         clear,
    bist_fail_logger_if.master           rd,
    output logic [$clog2(DEPTH+1)-1:0]   log_count,
    output logic [CNT_WIDTH-1:0]         total_fails,
    output logic                         overflow,
    output logic                         run_done,
    output logic                         pass,
    output logic                         repairable
);
    localparam int LC_W  = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [LC_W-1:0]      LC_ONE   = LC_W'(1);
    localparam logic [LC_W-1:0]      LC_DEPTH = LC_W'(DEPTH);
    localparam logic [LC_W-1:0]      LC_SPARE = LC_W'(SPARE_ROWS);
    localparam logic [PTR_W-1:0]     PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    typedef enum logic [1:0] {S_IDLE, S_LOG, S_DRAIN, S_DONE} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] entry_addr [DEPTH];
    logic [WORD_WIDTH-1:0] entry_data [DEPTH];
    logic [DEPTH-1:0]      entry_vld;
    logic [PTR_W-1:0]      rd_ptr;

    logic                  fail_s;
    logic                  hit;
    logic                  cap;
    logic                  full;
    logic                  wr_en;
    logic                  ovf_nxt;
    logic [CNT_WIDTH-1:0]  tf_nxt;
    logic [LC_W-1:0]       lc_nxt;
    logic [PTR_W-1:0]      wr_idx;
    logic [PTR_W-1:0]      ptr_inc;
    logic                  last;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [WORD_WIDTH-1:0] head_data;

    // Parallel address match against registered valid entries only.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_vld[i] && (entry_addr[i] == fail_addr)) begin
                hit = 1'b1;
            end
        end
    end

    // Next-cycle log bookkeeping; the LOG exit decision uses these so a
    // trailing fail in the last sampled cycle still lands in the readout.
    always_comb begin
        fail_s = 1'b0;
        if (fail) begin
            fail_s = 1'b1;
        end
        cap     = (state == S_LOG) && fail_s;
        full    = (log_count == LC_DEPTH);
        wr_en   = cap && !hit && !full;
        ovf_nxt = overflow | (cap && !hit && full);
        tf_nxt  = total_fails;
        if (cap && (total_fails != '1)) begin
            tf_nxt = total_fails + CNT_ONE;
        end
        lc_nxt    = wr_en ? (log_count + LC_ONE) : log_count;
        wr_idx    = PTR_W'(log_count);
        ptr_inc   = rd_ptr + PTR_ONE;
        last      = ((LC_W'(rd_ptr) + LC_ONE) == log_count);
        head_addr = (wr_en && (wr_idx == '0)) ? fail_addr : entry_addr[0];
        head_data = (wr_en && (wr_idx == '0)) ? fail_data : entry_data[0];
    end

    // Sequencing FSM; also owns the log storage and all registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            entry_vld   <= '0;
            rd_ptr      <= '0;
            log_count   <= '0;
            total_fails <= '0;
            overflow    <= 1'b0;
            run_done    <= 1'b0;
            pass        <= 1'b0;
            repairable  <= 1'b0;
            rd.rd_valid <= 1'b0;
            rd.rd_addr  <= '0;
            rd.rd_data  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entry_addr[i] <= '0;
                entry_data[i] <= '0;
            end
        end else if (clear) begin
            state       <= S_IDLE;
            entry_vld   <= '0;
            rd_ptr      <= '0;
            log_count   <= '0;
            total_fails <= '0;
            overflow    <= 1'b0;
            run_done    <= 1'b0;
            pass        <= 1'b0;
            repairable  <= 1'b0;
            rd.rd_valid <= 1'b0;
            rd.rd_addr  <= '0;
            rd.rd_data  <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (test_active) begin
                        state       <= S_LOG;
                        entry_vld   <= '0;
                        rd_ptr      <= '0;
                        log_count   <= '0;
                        total_fails <= '0;
                        overflow    <= 1'b0;
                        run_done    <= 1'b0;
                        pass        <= 1'b0;
                        repairable  <= 1'b0;
                    end
                end
                S_LOG: begin
                    total_fails <= tf_nxt;
                    log_count   <= lc_nxt;
                    overflow    <= ovf_nxt;
                    if (wr_en) begin
                        entry_addr[wr_idx] <= fail_addr;
                        entry_data[wr_idx] <= fail_data;
                        entry_vld[wr_idx]  <= 1'b1;
                    end
                    if (!test_active) begin
                        rd_ptr <= '0;
                        if (lc_nxt != '0) begin
                            state       <= S_DRAIN;
                            rd.rd_valid <= 1'b1;
                            rd.rd_addr  <= head_addr;
                            rd.rd_data  <= head_data;
                        end else begin
                            state      <= S_DONE;
                            run_done   <= 1'b1;
                            pass       <= (tf_nxt == '0);
                            repairable <= !ovf_nxt && (lc_nxt <= LC_SPARE);
                        end
                    end
                end
                S_DRAIN: begin
                    if (rd.rd_ready) begin
                        if (last) begin
                            state       <= S_DONE;
                            rd.rd_valid <= 1'b0;
                            rd.rd_addr  <= '0;
                            rd.rd_data  <= '0;
                            run_done    <= 1'b1;
                            pass        <= (total_fails == '0);
                            repairable  <= !overflow && (log_count <= LC_SPARE);
                        end else begin
                            rd_ptr     <= ptr_inc;
                            rd.rd_addr <= entry_addr[ptr_inc];
                            rd.rd_data <= entry_data[ptr_inc];
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bist_fail_logger.sv
// Directed bench for bist_fail_logger: a small reference model of the dedup log
// pushes expected readout entries to a queue as fails are driven; entries are
// popped and compared when the DUT hands them out.
module tb_bist_fail_logger;
    localparam int AW    = 8;
    localparam int WW    = 4;
    localparam int DEPTH = 8;
    localparam int SPARE = 2;
    localparam int CW    = 10;
    localparam int LCW   = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          test_active = 1'b0;
    logic          fail = 1'b0;
    logic [AW-1:0] fail_addr = '0;
    logic [WW-1:0] fail_data = '0;
    logic          clear = 1'b0;
    logic [LCW-1:0] log_count;
    logic [CW-1:0] total_fails;
    logic          overflow, run_done, pass, repairable;

    bist_fail_logger_if #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW)) rdif ();

    bist_fail_logger #(
        .ADDR_WIDTH(AW), .WORD_WIDTH(WW), .DEPTH(DEPTH),
        .SPARE_ROWS(SPARE), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst), .test_active(test_active), .fail(fail),
        .fail_addr(fail_addr), .fail_data(fail_data), .clear(clear),
        .rd(rdif), .log_count(log_count), .total_fails(total_fails),
        .overflow(overflow), .run_done(run_done), .pass(pass),
        .repairable(repairable)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [WW-1:0] d;
    } ent_t;

    int            errors = 0;
    int            checks = 0;
    ent_t          exp_q[$];
    logic [AW-1:0] seen_q[$];
    int            mdl_tf;
    bit            mdl_ovf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        exp_q.delete();
        seen_q.delete();
        mdl_tf  = 0;
        mdl_ovf = 1'b0;
    endtask

    task automatic model_fail(input logic [AW-1:0] a, input logic [WW-1:0] d);
        bit found;
        found = 1'b0;
        mdl_tf++;
        foreach (seen_q[i]) if (seen_q[i] == a) found = 1'b1;
        if (!found) begin
            if (seen_q.size() < DEPTH) begin
                seen_q.push_back(a);
                exp_q.push_back('{a: a, d: d});
            end else begin
                mdl_ovf = 1'b1;
            end
        end
    endtask

    task automatic new_run();
        model_reset();
        test_active = 1'b1;
        tick();
    endtask

    task automatic do_fail(input logic [AW-1:0] a, input logic [WW-1:0] d);
        fail = 1'b1; fail_addr = a; fail_data = d;
        model_fail(a, d);
        tick();
        fail = 1'b0;
    endtask

    task automatic end_run();
        test_active = 1'b0;
        tick();
    endtask

    task automatic check_log(input string tag);
        check({tag, "_log_count"}, 32'(log_count), 32'(seen_q.size()));
        check({tag, "_total"}, 32'(total_fails), 32'(mdl_tf));
        check({tag, "_overflow"}, 32'(overflow), 32'(mdl_ovf));
    endtask

    task automatic check_verdict(input string tag);
        check({tag, "_run_done"}, 32'(run_done), 32'd1);
        check({tag, "_pass"}, 32'(pass), 32'(mdl_tf == 0));
        check({tag, "_repairable"}, 32'(repairable), 32'(!mdl_ovf && seen_q.size() <= SPARE));
    endtask

    // pat[c] is rd_ready in drain cycle c; ready stays high after plen cycles.
    task automatic drain(input string tag, input logic [15:0] pat, input int plen, input int budget);
        int            n_exp, xfers;
        bit            stalled, done;
        logic          rdy;
        logic [AW-1:0] ha;
        logic [WW-1:0] hd;
        ent_t          e;
        n_exp = exp_q.size(); xfers = 0; stalled = 1'b0; done = 1'b0;
        ha = '0; hd = '0;
        for (int c = 0; c < budget && !done; c++) begin
            rdy = (c < plen) ? pat[c] : 1'b1;
            rdif.rd_ready = rdy;
            if (stalled) begin
                check({tag, "_hold_addr"}, 32'(rdif.rd_addr), 32'(ha));
                check({tag, "_hold_data"}, 32'(rdif.rd_data), 32'(hd));
            end
            stalled = 1'b0;
            if (rdif.rd_valid) begin
                if (rdy) begin
                    if (exp_q.size() == 0) begin
                        check({tag, "_extra_xfer"}, 32'(xfers + 1), 32'(n_exp));
                        done = 1'b1;
                    end else begin
                        e = exp_q.pop_front();
                        check({tag, "_rd_addr"}, 32'(rdif.rd_addr), 32'(e.a));
                        check({tag, "_rd_data"}, 32'(rdif.rd_data), 32'(e.d));
                        xfers++;
                    end
                end else begin
                    stalled = 1'b1;
                    ha = rdif.rd_addr;
                    hd = rdif.rd_data;
                end
            end
            tick();
            if (!done && xfers == n_exp && n_exp > 0) begin
                check({tag, "_done_after_last"}, 32'(run_done), 32'd1);
                check({tag, "_valid_after_last"}, 32'(rdif.rd_valid), 32'd0);
                done = 1'b1;
            end
        end
        rdif.rd_ready = 1'b0;
        check({tag, "_xfers"}, 32'(xfers), 32'(n_exp));
    endtask

    initial begin
        int  wait_c;
        bit  saw_valid;
        rdif.rd_ready = 1'b0;
        model_reset();

        // Reset state
        #3;
        check("rst_rd_valid", 32'(rdif.rd_valid), 32'd0);
        check("rst_log_count", 32'(log_count), 32'd0);
        check("rst_run_done", 32'(run_done), 32'd0);
        check("rst_total", 32'(total_fails), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Clean run: long run with no fails, empty log straight to DONE
        new_run();
        repeat (1024) tick();
        end_run();
        saw_valid = 1'b0;
        for (wait_c = 0; wait_c < 8 && !run_done; wait_c++) begin
            if (rdif.rd_valid) saw_valid = 1'b1;
            tick();
        end
        if (rdif.rd_valid) saw_valid = 1'b1;
        check("clean_no_rd_valid", 32'(saw_valid), 32'd0);
        check_log("clean");
        check_verdict("clean");

        // Dedup, including a back-to-back repeat of a freshly logged address
        new_run();
        do_fail(8'h12, 4'hA);
        do_fail(8'h12, 4'h5);
        tick();
        do_fail(8'h34, 4'h3);
        do_fail(8'h12, 4'h7);
        check_log("dedup");
        end_run();
        drain("dedup", 16'hFFFF, 16, 20);
        check_verdict("dedup");
        check("dedup_total_done", 32'(total_fails), 32'd4);

        // Overflow: 10 unique addresses into 8 entries
        new_run();
        for (int i = 0; i < 10; i++) do_fail(AW'(8'h40 + i), WW'(i));
        check_log("ovf");
        end_run();
        drain("ovf", 16'hFFFF, 16, 30);
        check_verdict("ovf");

        // Backpressure: rd_ready 1,0,0,1,1
        new_run();
        do_fail(8'hA1, 4'h1);
        do_fail(8'hB2, 4'h2);
        do_fail(8'hC3, 4'h3);
        end_run();
        drain("bp", 16'b11001, 5, 20);
        check_verdict("bp");

        // Trailing fail in the first cycle test_active is low
        new_run();
        tick();
        test_active = 1'b0;
        fail = 1'b1; fail_addr = 8'h77; fail_data = 4'h9;
        model_fail(8'h77, 4'h9);
        tick();
        fail = 1'b0;
        check_log("trail");
        drain("trail", 16'hFFFF, 16, 10);
        check_verdict("trail");

        // Asynchronous reset in the middle of DRAIN
        new_run();
        do_fail(8'h01, 4'h1);
        do_fail(8'h02, 4'h2);
        do_fail(8'h03, 4'h3);
        end_run();
        tick();
        check("mid_drain_valid", 32'(rdif.rd_valid), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("arst_rd_valid", 32'(rdif.rd_valid), 32'd0);
        check("arst_rd_addr", 32'(rdif.rd_addr), 32'd0);
        check("arst_log_count", 32'(log_count), 32'd0);
        check("arst_total", 32'(total_fails), 32'd0);
        check("arst_run_done", 32'(run_done), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        tick();

        // clear wins over test_active from DONE: lands in IDLE, not LOG
        new_run();
        do_fail(8'h5A, 4'h2);
        end_run();
        drain("pre_clr", 16'hFFFF, 16, 10);
        clear = 1'b1; test_active = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_run_done", 32'(run_done), 32'd0);
        check("clr_log_count", 32'(log_count), 32'd0);
        check("clr_total", 32'(total_fails), 32'd0);
        fail = 1'b1; fail_addr = 8'h11; fail_data = 4'h1;
        tick();
        fail = 1'b0;
        check("clr_idle_no_capture", 32'(total_fails), 32'd0);
        test_active = 1'b0;
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_final_done", 32'(run_done), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
